// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle for uart_rx: received data, valid/ready and error pulses.
// master = receiver side, slave = consumer side.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_parity_err;

  modport master (
    output rx_data, rx_data_valid, rx_frame_err, rx_overrun, rx_parity_err,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_frame_err, rx_overrun, rx_parity_err,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output and one-cycle error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLK_FRE   = 27,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         rx_pin,
  uart_rx_if.master    bus
);

  localparam int unsigned CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int unsigned HALF  = CYCLE / 2;
  localparam int unsigned CNT_W = $clog2(CYCLE + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               prev_q, prev_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               deliver_c;
`ifdef UART_RX_PARITY_EN
  logic               parity_err_q, parity_err_d;
  logic               par_bad_q, par_bad_d;
`endif

  // Next-state, datapath and output pulses
  always_comb begin
    sync1_d     = rx_pin;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~bus.rx_data_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver_c   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        cycle_cnt_d = '0;
        if (prev_q && !sync2_q) state_d = START;
      end
      START: begin
        if (cycle_cnt_q == CNT_W'(HALF - 1)) begin
          cycle_cnt_d = '0;
          bit_cnt_d   = 3'd0;
          state_d     = sync2_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d   = 1'b0;
`endif
        end
      end
      DATA: begin
        if (cycle_cnt_q == CNT_W'(CYCLE - 1)) begin
          cycle_cnt_d         = '0;
          shift_d[bit_cnt_q]  = sync2_q;
          bit_cnt_d           = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cycle_cnt_q == CNT_W'(CYCLE - 1)) begin
          cycle_cnt_d = '0;
          state_d     = STOP;
          if ((^shift_q) ^ sync2_q) begin
            parity_err_d = 1'b1;
            par_bad_d    = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge
        if (cycle_cnt_q == CNT_W'(CYCLE - 1)) begin
          cycle_cnt_d = '0;
          state_d     = IDLE;
          if (sync2_q) begin
`ifdef UART_RX_PARITY_EN
            deliver_c = ~par_bad_q;
`else
            deliver_c = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        cycle_cnt_d = '0;
      end
    endcase

    // A new byte always wins; overrun only if the old one was not taken this edge
    if (deliver_c) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~bus.rx_data_ready;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      par_bad_q    <= par_bad_d;
    end
  end

  assign bus.rx_parity_err = parity_err_q;
`else
  assign bus.rx_parity_err = 1'b0;
`endif

  assign bus.rx_data       = data_q;
  assign bus.rx_data_valid = valid_q;
  assign bus.rx_frame_err  = frame_err_q;
  assign bus.rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CYCLE=10/HALF=5: directed scenarios plus random frames
// compared against a frame-level model (expected byte queue and error counts).
module tb_uart_rx;

  localparam int CYC = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + 5 + 10 * CYC;
`else
  localparam int LAT = 3 + 5 + 9 * CYC;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pin = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLK_FRE(1), .BAUD_RATE(100000)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .rx_pin  (rx_pin),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: observed accepted bytes, pulse counts, last valid rising cycle
  logic [7:0] got[$];
  int valid_cycles = 0;
  int n_rise = 0;
  int rise_cyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_data_valid === 1'b1) begin
        valid_cycles++;
        if (!valid_prev) begin
          n_rise++;
          rise_cyc = cyc;
        end
        if (bus.rx_data_ready === 1'b1) got.push_back(bus.rx_data);
      end
      if (bus.rx_frame_err === 1'b1) n_ferr++;
      if (bus.rx_overrun === 1'b1) n_ovr++;
      if (bus.rx_parity_err === 1'b1) n_perr++;
    end
    valid_prev = (bus.rx_data_valid === 1'b1);
  end

  // Reference model state
  logic [7:0] exp_q[$];
  int exp_ferr = 0;
  int exp_perr = 0;
  int exp_ovr = 0;
  int chk_idx = 0;
  int fall_cyc = 0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx_pin = b;
    repeat (CYC) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; par_ok=0 sends the wrong parity bit (parity builds only)
  task automatic send_and_model(input logic [7:0] d, input logic stop_b, input logic par_ok);
    fall_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ ~par_ok);
`endif
    bit_out(stop_b);
    if (!stop_b) exp_ferr++;
    if (!par_ok) exp_perr++;
    if (stop_b && par_ok) exp_q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size() && i < got.size(); i++)
      check({tag, "_data"}, 32'(got[i]), 32'(exp_q[i]));
    chk_idx = exp_q.size();
    check({tag, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
    check({tag, "_perr"}, 32'(n_perr), 32'(exp_perr));
    check({tag, "_ovr"},  32'(n_ovr),  32'(exp_ovr));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  32'(bus.rx_data), 32'h00);
    check({tag, "_valid"}, 32'(bus.rx_data_valid), 32'h0);
    check({tag, "_ferr"},  32'(bus.rx_frame_err), 32'h0);
    check({tag, "_ovr"},   32'(bus.rx_overrun), 32'h0);
    check({tag, "_perr"},  32'(bus.rx_parity_err), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0;
    int r0;
    int lat;
    logic [7:0] d;
    logic sb;
    logic pok;

    bus.rx_data_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(10);

    // Single frame with latency and pulse width
    vc0 = valid_cycles;
    send_and_model(8'hA5, 1'b1, 1'b1);
    idle(20);
    lat = rise_cyc - fall_cyc;
    check("single_latency", (lat >= LAT - 1 && lat <= LAT + 1) ? 32'(LAT) : 32'(lat), 32'(LAT));
    check("single_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    check_all("single");

    // Back-to-back frames
    send_and_model(8'h00, 1'b1, 1'b1);
    send_and_model(8'hFF, 1'b1, 1'b1);
    idle(20);
    check_all("b2b");

    // Glitch shorter than half a bit
    r0 = n_rise;
    rx_pin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(30);
    check("glitch_no_valid", 32'(n_rise - r0), 32'd0);
    send_and_model(8'h3C, 1'b1, 1'b1);
    idle(20);
    check_all("glitch");

    // Framing error, then recovery
    send_and_model(8'h55, 1'b0, 1'b1);
    idle(20);
    check_all("frame");
    send_and_model(8'h12, 1'b1, 1'b1);
    idle(20);
    check_all("frame_next");

    // Overrun with consumer stalled
    bus.rx_data_ready = 1'b0;
    send_and_model(8'h11, 1'b1, 1'b1);
    void'(exp_q.pop_back());
    send_and_model(8'h22, 1'b1, 1'b1);
    void'(exp_q.pop_back());
    idle(20);
    exp_ovr++;
    check("ovr_valid", 32'(bus.rx_data_valid), 32'd1);
    check("ovr_data", 32'(bus.rx_data), 32'h22);
    check_all("ovr_hold");
    bus.rx_data_ready = 1'b1;
    exp_q.push_back(8'h22);
    @(posedge clk);
    #1;
    check("ovr_valid_drop", 32'(bus.rx_data_valid), 32'd0);
    idle(5);
    check_all("ovr_accept");

    // Reset in the middle of bit 4 of 8'hC3; an unread byte is held so rx_data reset is visible
    bus.rx_data_ready = 1'b0;
    send_and_model(8'h5A, 1'b1, 1'b1);
    void'(exp_q.pop_back());
    idle(5);
    r0 = n_rise;
    d = 8'hC3;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(d[i]);
    rx_pin = d[4];
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rx_pin = 1'b1;
    bus.rx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(150);
    check("rst_no_valid", 32'(n_rise - r0), 32'd0);
    send_and_model(8'h81, 1'b1, 1'b1);
    idle(20);
    check_all("rst_next");

`ifdef UART_RX_PARITY_EN
    send_and_model(8'h07, 1'b1, 1'b0);
    idle(20);
    check_all("par_bad");
    send_and_model(8'h07, 1'b1, 1'b1);
    idle(20);
    check_all("par_good");
`endif

    // Random frames, some with bad stop (and parity) bits
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      sb = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 3) != 0);
`else
      pok = 1'b1;
`endif
      send_and_model(d, sb, pok);
      if (!sb || ($urandom_range(0, 1) != 0)) idle($urandom_range(CYC, 3 * CYC));
    end
    idle(30);
    check_all("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
